// File: rtl/nes_palette_ram_ctrl.sv
// nes_palette_ram_ctrl: 64x15 palette RAM shared by pixel lookup and host byte loader.
// Optional host readback port (rd_*) is enabled by defining PAL_READBACK_EN.
module nes_palette_ram_ctrl #(
  parameter int ENTRIES    = 64,
  parameter int DATA_W     = 15,
  parameter int FIFO_DEPTH = 2,
  localparam int IW = $clog2(ENTRIES),
  localparam int PW = $clog2(FIFO_DEPTH),
  localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              pix_req,
  input  logic [IW-1:0]     pix_index,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  input  logic              ld_wr,
  input  logic [IW:0]       ld_addr,
  input  logic [7:0]        ld_data,
  input  logic              ld_end,
  output logic              ld_busy,
  output logic              ld_done,
  output logic              pal_custom_valid,
  output logic              err_seq,
  output logic              err_ovf
`ifdef PAL_READBACK_EN
  ,
  input  logic              rd_req,
  input  logic [IW-1:0]     rd_index,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HAVE_LO,
    S_DRAIN
  } state_t;

  localparam int FW = IW + DATA_W;

  state_t              r_state;
  state_t              w_state_n;
  logic [DATA_W-1:0]   r_mem [ENTRIES];
  logic [FW-1:0]       r_fifo [FIFO_DEPTH];
  logic [PW-1:0]       r_wp;
  logic [PW-1:0]       r_rp;
  logic [CW-1:0]       r_cnt;
  logic [CW-1:0]       w_cnt_n;
  logic                r_busy;
  logic [7:0]          r_lo;
  logic [IW-1:0]       r_lo_idx;
  logic                r_held;
  logic [ENTRIES-1:0]  r_mask;
  logic [ENTRIES-1:0]  w_mask_n;
  logic                r_new_load;
  logic [DATA_W-1:0]   r_pix_data;
  logic                r_pix_valid;
  logic                r_done;
  logic                r_pcv;
  logic                r_err_seq;
  logic                r_err_ovf;

  logic                w_wr_ok;
  logic                w_odd;
  logic [IW-1:0]       w_idx;
  logic                w_empty;
  logic                w_new;
  logic                w_commit;
  logic [FW-1:0]       w_head;
  logic [IW-1:0]       w_head_idx;
  logic [DATA_W-1:0]   w_head_data;
  logic                w_push;
  logic                w_lo_load;
  logic                w_held_n;
  logic                w_set_seq;
  logic                w_set_ovf;
  logic                w_done;
  logic                w_unused;

  assign w_unused    = ld_data[7];
  assign w_wr_ok     = ld_wr & ~r_busy;
  assign w_odd       = ld_addr[0];
  assign w_idx       = ld_addr[IW:1];
  assign w_empty     = (r_cnt == '0);
  assign w_new       = ld_wr & r_new_load;
  assign w_head      = r_fifo[r_rp];
  assign w_head_idx  = w_head[FW-1:DATA_W];
  assign w_head_data = w_head[DATA_W-1:0];
  assign w_cnt_n     = r_cnt + CW'(w_push) - CW'(w_commit);

`ifdef PAL_READBACK_EN
  logic              r_rd_valid;
  logic [DATA_W-1:0] r_rd_data;
  logic              w_rd_srv;

  // One service per request: host drops rd_req after seeing rd_valid
  assign w_rd_srv = rd_req & ~pix_req & ~r_rd_valid;
  assign w_commit = reset_n & ~w_empty & ~pix_req & ~w_rd_srv;
  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= w_rd_srv;
      if (w_rd_srv) r_rd_data <= r_mem[rd_index];
    end
  end
`else
  assign w_commit = reset_n & ~w_empty & ~pix_req;
`endif

  always_comb begin
    w_state_n = r_state;
    w_push    = 1'b0;
    w_lo_load = 1'b0;
    w_set_seq = 1'b0;
    w_done    = 1'b0;
    w_held_n  = r_held;
    w_set_ovf = ld_wr & r_busy;
    unique case (r_state)
      S_IDLE: begin
        if (w_wr_ok && !w_odd) begin
          w_lo_load = 1'b1;
          w_state_n = S_HAVE_LO;
        end else if (w_wr_ok) begin
          w_set_seq = 1'b1;
        end
      end
      S_HAVE_LO: begin
        if (w_wr_ok && !w_odd) begin
          w_lo_load = 1'b1;
        end else if (w_wr_ok && w_idx == r_lo_idx) begin
          w_push    = 1'b1;
          w_state_n = S_IDLE;
        end else if (w_wr_ok) begin
          w_set_seq = 1'b1;
          w_state_n = S_IDLE;
        end
      end
      S_DRAIN: begin
        w_set_seq = w_wr_ok;
        if (w_empty) begin
          w_done    = 1'b1;
          w_set_seq = w_wr_ok | r_held;
          w_held_n  = 1'b0;
          w_state_n = S_IDLE;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
    if (ld_end && r_state != S_DRAIN) begin
      w_held_n  = (w_state_n == S_HAVE_LO);
      w_state_n = S_DRAIN;
    end
  end

  always_comb begin
    w_mask_n = w_new ? '0 : r_mask;
    if (w_commit) w_mask_n[w_head_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wp] <= {w_idx, ld_data[6:0], r_lo};
    if (w_commit) r_mem[w_head_idx] <= w_head_data;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_wp        <= '0;
      r_rp        <= '0;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
      r_lo        <= '0;
      r_lo_idx    <= '0;
      r_held      <= 1'b0;
      r_mask      <= '0;
      r_new_load  <= 1'b1;
      r_pix_data  <= '0;
      r_pix_valid <= 1'b0;
      r_done      <= 1'b0;
      r_pcv       <= 1'b0;
      r_err_seq   <= 1'b0;
      r_err_ovf   <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_held      <= w_held_n;
      r_cnt       <= w_cnt_n;
      r_busy      <= (w_cnt_n == CW'(FIFO_DEPTH));
      r_mask      <= w_mask_n;
      r_done      <= w_done;
      r_pix_valid <= pix_req;
      r_new_load  <= (r_new_load & ~ld_wr) | w_done;
      r_err_seq   <= (r_err_seq & ~w_new) | w_set_seq;
      r_err_ovf   <= (r_err_ovf & ~w_new) | w_set_ovf;
      if (w_lo_load) begin
        r_lo     <= ld_data;
        r_lo_idx <= w_idx;
      end
      if (w_push) r_wp <= r_wp + PW'(1);
      if (w_commit) r_rp <= r_rp + PW'(1);
      if (pix_req) r_pix_data <= r_mem[pix_index];
      if (w_new) r_pcv <= 1'b0;
      else if (w_done) r_pcv <= &r_mask;
    end
  end

  assign pix_data         = r_pix_data;
  assign pix_valid        = r_pix_valid;
  assign ld_busy          = r_busy;
  assign ld_done          = r_done;
  assign pal_custom_valid = r_pcv;
  assign err_seq          = r_err_seq;
  assign err_ovf          = r_err_ovf;

endmodule
